// File: rtl/mipi_dphy_pkg.sv
// Shared types and constants for the MIPI D-PHY data-lane transmitter.
//   state_e   : lane sequencer states
//   SYNC_BYTE : HS leader byte, sent LSB first
//   LP11/01/00: low-power line levels packed as {ap, an}
package mipi_dphy_pkg;

  typedef enum logic [3:0] {
    StDis,
    StStop,
    StHsRqst,
    StHsPrep,
    StHsZero,
    StHsSync,
    StHsData,
    StHsTrail,
    StHsExit
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef logic [1:0] lp_t;  // {ap, an}
  localparam lp_t LP11 = 2'b11;
  localparam lp_t LP01 = 2'b01;
  localparam lp_t LP00 = 2'b00;

  // States where the serializer is shifting out a byte
  function automatic logic is_hs_byte(state_e s);
    return (s == StHsSync) || (s == StHsData);
  endfunction

endpackage

// File: rtl/mipi_dphy_lane_tx_if.sv
// Byte-source handshake between the packet source and the lane transmitter.
//   txreq   : burst request (level)
//   txd     : payload byte, sent LSB first
//   txvalid : txd valid
//   txready : txd consumed on this cycle when txvalid=1
// master = packet source, slave = lane transmitter.
interface mipi_dphy_lane_tx_if;

  logic       txreq;
  logic [7:0] txd;
  logic       txvalid;
  logic       txready;

  modport master (output txreq, output txd, output txvalid, input txready);
  modport slave  (input txreq, input txd, input txvalid, output txready);

endinterface

// File: rtl/mipi_dphy_tx_ser.sv
// 8-bit LSB-first shift register with bit counter for the HS payload path.
//   clk, rst_n : clock, async active-low reset
//   load       : take din as the next byte, bit index restarts at 0
//   shift      : advance to the next bit
//   din        : byte to load
//   bit_nxt    : bit that will be on the line after this edge
//   last       : current bit is bit 7 (byte boundary)
//   last_nxt   : bit after this edge is bit 7
module mipi_dphy_tx_ser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       bit_nxt,
  output logic       last,
  output logic       last_nxt
);

  logic [7:0] sreg_q, sreg_d;
  logic [2:0] idx_q, idx_d;

  always_comb begin
    sreg_d = sreg_q;
    idx_d  = idx_q;
    if (load) begin
      sreg_d = din;
      idx_d  = 3'd0;
    end else if (shift) begin
      sreg_d = {1'b0, sreg_q[7:1]};
      idx_d  = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      idx_q  <= idx_d;
    end
  end

  // The lane output is registered from the next state, so expose next-cycle values
  assign bit_nxt  = sreg_d[0];
  assign last     = (idx_q == 3'd7);
  assign last_nxt = (idx_d == 3'd7);

endmodule

// File: rtl/mipi_dphy_lane_tx.sv
// Transmit sequencer for one MIPI D-PHY data lane (one HS bit per clk).
// Generates LP-01 / LP-00 / HS-0 / sync / payload / trail / LP-11 and drives the
// pad buffer controls.
//   clk, rst_n : HS bit clock, async active-low reset
//   en         : lane enable, low tristates the pad
//   src        : byte-source handshake (slave side)
//   busy       : high outside DIS and STOP
//   ap, an     : P/N drive values
//   tp, tn     : P/N tristate (1 = high-Z)
//   hssel      : HS mode select
module mipi_dphy_lane_tx
  import mipi_dphy_pkg::*;
#(
  parameter int unsigned T_LPX        = 8,
  parameter int unsigned T_HS_PREPARE = 6,
  parameter int unsigned T_HS_ZERO    = 16,
  parameter int unsigned T_HS_TRAIL   = 10,
  parameter int unsigned T_HS_EXIT    = 12,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  mipi_dphy_lane_tx_if.slave   src,
  output logic                 busy,
  output logic                 ap,
  output logic                 an,
  output logic                 tp,
  output logic                 tn,
  output logic                 hssel
);

  localparam logic [CNT_W-1:0] LpxLd   = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] PrepLd  = CNT_W'(T_HS_PREPARE - 1);
  localparam logic [CNT_W-1:0] ZeroLd  = CNT_W'(T_HS_ZERO - 1);
  localparam logic [CNT_W-1:0] TrailLd = CNT_W'(T_HS_TRAIL - 1);
  localparam logic [CNT_W-1:0] ExitLd  = CNT_W'(T_HS_EXIT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;

  logic ap_q, an_q, tp_q, tn_q, hssel_q, txready_q, busy_q;
  logic ap_d, an_d, tp_d, tn_d, hssel_d, txready_d, busy_d;
  logic trail_bit;

  logic       load_sync, load_data, ser_shift;
  logic [7:0] ser_din;
  logic       ser_bit_nxt, ser_last, ser_last_nxt;

  assign ser_din = load_sync ? SYNC_BYTE : src.txd;

  mipi_dphy_tx_ser u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_sync | load_data),
    .shift    (ser_shift),
    .din      (ser_din),
    .bit_nxt  (ser_bit_nxt),
    .last     (ser_last),
    .last_nxt (ser_last_nxt)
  );

  assign cnt_zero = (cnt_q == '0);

  // Next state and timing counter
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    load_sync = 1'b0;
    load_data = 1'b0;
    ser_shift = 1'b0;
    unique case (st_q)
      StDis: begin
        cnt_d = '0;
        if (en) st_d = StStop;
      end
      StStop: begin
        cnt_d = '0;
        // en has priority over a coincident request
        if (!en) begin
          st_d = StDis;
        end else if (src.txreq && src.txvalid) begin
          st_d  = StHsRqst;
          cnt_d = LpxLd;
        end
      end
      StHsRqst: begin
        if (!en) begin
          st_d  = StHsExit;
          cnt_d = ExitLd;
        end else if (cnt_zero) begin
          st_d  = StHsPrep;
          cnt_d = PrepLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHsPrep: begin
        if (!en) begin
          st_d  = StHsExit;
          cnt_d = ExitLd;
        end else if (cnt_zero) begin
          st_d  = StHsZero;
          cnt_d = ZeroLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHsZero: begin
        // Once in HS the sync byte always goes out; en is honoured at the boundary
        if (cnt_zero) begin
          st_d      = StHsSync;
          load_sync = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHsSync, StHsData: begin
        if (ser_last) begin
          if (txready_q && src.txvalid) begin
            st_d      = StHsData;
            load_data = 1'b1;
          end else begin
            st_d  = StHsTrail;
            cnt_d = TrailLd;
          end
        end else begin
          ser_shift = 1'b1;
        end
      end
      StHsTrail: begin
        if (cnt_zero) begin
          st_d  = StHsExit;
          cnt_d = ExitLd;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHsExit: begin
        if (cnt_zero) begin
          st_d  = en ? StStop : StDis;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        st_d  = StDis;
        cnt_d = '0;
      end
    endcase
  end

  // Output decode from the next state
  always_comb begin
    ap_d      = 1'b1;
    an_d      = 1'b1;
    tp_d      = 1'b0;
    tn_d      = 1'b0;
    hssel_d   = 1'b0;
    // Trail inverts the last bit on entry, then holds it
    trail_bit = (st_q == StHsTrail) ? ap_q : ~ap_q;
    unique case (st_d)
      StDis: begin
        tp_d = 1'b1;
        tn_d = 1'b1;
      end
      StStop, StHsExit: {ap_d, an_d} = LP11;
      StHsRqst:         {ap_d, an_d} = LP01;
      StHsPrep:         {ap_d, an_d} = LP00;
      StHsZero: begin
        hssel_d = 1'b1;
        ap_d    = 1'b0;
        an_d    = 1'b1;
      end
      StHsSync, StHsData: begin
        hssel_d = 1'b1;
        ap_d    = ser_bit_nxt;
        an_d    = ~ser_bit_nxt;
      end
      StHsTrail: begin
        hssel_d = 1'b1;
        ap_d    = trail_bit;
        an_d    = ~trail_bit;
      end
      default: begin
        tp_d = 1'b1;
        tn_d = 1'b1;
      end
    endcase
    txready_d = is_hs_byte(st_d) && ser_last_nxt && src.txreq && en;
    busy_d    = !((st_d == StDis) || (st_d == StStop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= StDis;
      cnt_q     <= '0;
      ap_q      <= 1'b1;
      an_q      <= 1'b1;
      tp_q      <= 1'b1;
      tn_q      <= 1'b1;
      hssel_q   <= 1'b0;
      txready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      ap_q      <= ap_d;
      an_q      <= an_d;
      tp_q      <= tp_d;
      tn_q      <= tn_d;
      hssel_q   <= hssel_d;
      txready_q <= txready_d;
      busy_q    <= busy_d;
    end
  end

  assign ap          = ap_q;
  assign an          = an_q;
  assign tp          = tp_q;
  assign tn          = tn_q;
  assign hssel       = hssel_q;
  assign busy        = busy_q;
  assign src.txready = txready_q;

endmodule

// File: tb/tb_mipi_dphy_lane_tx.sv
// Self-checking bench for mipi_dphy_lane_tx. The expected pad waveform of each
// burst is computed from the protocol timeline (phase lengths, byte boundaries,
// enable/request levels) and compared cycle by cycle.
module tb_mipi_dphy_lane_tx;

  logic clk = 1'b0;
  logic rst_n, en;
  logic busy, ap, an, tp, tn, hssel;

  mipi_dphy_lane_tx_if bus ();

  mipi_dphy_lane_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .src   (bus),
    .busy  (busy),
    .ap    (ap),
    .an    (an),
    .tp    (tp),
    .tn    (tn),
    .hssel (hssel)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pay [8];
  logic [7:0] sync_b = 8'hB8;

  // Observed vector: {busy, txready, hssel, ap, an, tp, tn}
  logic [6:0] obs_v;
  assign obs_v = {busy, bus.txready, hssel, ap, an, tp, tn};

  localparam logic [6:0] V_DIS  = 7'b0001111;
  localparam logic [6:0] V_STOP = 7'b0001100;
  localparam logic [6:0] V_LP01 = 7'b1000100;
  localparam logic [6:0] V_LP00 = 7'b1000000;
  localparam logic [6:0] V_HS0  = 7'b1010100;
  localparam logic [6:0] V_EXIT = 7'b1001100;

  task automatic check(input string tag, input int step, input logic [6:0] exp);
    checks++;
    assert (obs_v === exp)
    else begin
      failures++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, obs_v, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one burst from STOP. nbytes bytes from pay[] are offered; d>0 drops en
  // right after step d; keep_req holds txreq after the last byte is taken.
  task automatic run_burst(input string tag, input int nbytes, input int d,
                           input bit keep_req);
    int nsent, tstart, total, k, j;
    logic lastb, b, rdy;
    logic [6:0] e;
    // Byte j is offered at boundary j (step 38+8j); taken if req, en and valid
    nsent = 0;
    for (int jj = 0; jj < nbytes; jj++) begin
      if ((d == 0) || (d >= 38 + 8 * jj)) nsent++;
      else break;
    end
    lastb  = (nsent == 0) ? sync_b[7] : pay[nsent-1][7];
    tstart = 39 + 8 * nsent;
    total  = tstart + 24;
    bus.txreq   = 1'b1;
    bus.txvalid = 1'b1;
    bus.txd     = pay[0];
    for (int s = 1; s <= total; s++) begin
      tick();
      if (s <= 8) e = V_LP01;
      else if (s <= 14) e = V_LP00;
      else if (s <= 30) e = V_HS0;
      else if (s < tstart) begin
        k   = s - 31;
        j   = k / 8;
        b   = (k < 8) ? sync_b[k] : pay[(k-8)/8][(k-8)%8];
        rdy = ((k % 8) == 7) && ((j < nbytes) || keep_req) && ((d == 0) || (d >= s));
        e   = {1'b1, rdy, 1'b1, b, ~b, 2'b00};
      end
      else if (s < tstart + 10) e = {1'b1, 1'b0, 1'b1, ~lastb, lastb, 2'b00};
      else if (s < tstart + 22) e = V_EXIT;
      else e = (d == 0) ? V_STOP : V_DIS;
      check(tag, s, e);
      if (s == d) en = 1'b0;
      if ((s >= 39) && (((s - 39) % 8) == 0) && (((s - 39) / 8) < nsent)) begin
        j = (s - 39) / 8;
        if (j + 1 < nbytes) bus.txd = pay[j+1];
        else begin
          bus.txvalid = 1'b0;
          if (!keep_req) bus.txreq = 1'b0;
        end
      end
      if (s == tstart) begin
        bus.txreq   = 1'b0;
        bus.txvalid = 1'b0;
      end
    end
    if (!en) begin
      en = 1'b1;
      tick();
      check({tag, "_reen"}, 0, V_STOP);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n       = 1'b1;
    en          = 1'b0;
    bus.txreq   = 1'b0;
    bus.txvalid = 1'b0;
    bus.txd     = 8'h00;
    #2 rst_n = 1'b0;
    #1 check("reset", 0, V_DIS);
    tick();
    tick();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("dis_hold", 0, V_DIS);
    en = 1'b1;
    tick();
    check("enable", 0, V_STOP);

    // en falling with a request in STOP: disable wins
    bus.txreq   = 1'b1;
    bus.txvalid = 1'b1;
    en          = 1'b0;
    tick();
    check("en_prio", 0, V_DIS);
    bus.txreq   = 1'b0;
    bus.txvalid = 1'b0;
    en          = 1'b1;
    tick();
    check("en_prio_stop", 0, V_STOP);

    pay[0] = 8'h5A;
    run_burst("single", 1, 0, 1'b0);

    pay[0] = 8'h01;
    pay[1] = 8'hFF;
    run_burst("b2b", 2, 0, 1'b0);

    n = $urandom_range(2, 5);
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    run_burst("rand", n, 0, 1'b0);

    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    run_burst("en_drop_bit3", 3, 41, 1'b0);

    pay[0] = 8'($urandom);
    run_burst("valid_low", 1, 0, 1'b1);

    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    run_burst("en_drop_rand", 4, int'($urandom_range(15, 60)), 1'b0);

    // Asynchronous reset in the middle of HS data
    pay[0]      = 8'($urandom);
    bus.txd     = pay[0];
    bus.txreq   = 1'b1;
    bus.txvalid = 1'b1;
    repeat (42) tick();
    bus.txreq   = 1'b0;
    bus.txvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", 0, V_DIS);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst", 0, V_STOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
